// File: rtl/uart_rx_deframer.sv
// UART receive deframer: 16x oversampled start detect, 5-8 data bits, optional parity, 1/2 stop bits.
// Optional feature macro RX_MAJORITY_VOTE_EN: 2-of-3 vote around mid-bit instead of a single sample.
module uart_rx_deframer #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       UARTCLK,
    input  logic       PRESET,
    input  logic       baud_tick_os,
    input  logic       UART_RXD,
    input  logic [3:0] number_data_receive,
    input  logic       parity_en,
    input  logic       parity_bit_mode,
    input  logic       stop_bit_twice,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       rx_busy
);

    localparam int CW = $clog2(OVERSAMPLE);
`ifdef RX_MAJORITY_VOTE_EN
    localparam logic [CW-1:0] DEC_PHASE = CW'(OVERSAMPLE / 2);
`else
    localparam logic [CW-1:0] DEC_PHASE = CW'(OVERSAMPLE / 2 - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
    } state_t;

    state_t            state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic              rxd_s;
    logic              rxd_prev_q;
    logic [CW-1:0]     tick_cnt_q;
    logic [2:0]        bit_cnt_q;
    logic [7:0]        shreg_q;
    logic [3:0]        nbits_q;
    logic              par_en_q;
    logic              par_even_q;
    logic              two_stop_q;
    logic              perr_q;
    logic              ferr_q;
    logic [7:0]        rx_data_q;
    logic              rx_valid_q;
    logic              parity_err_q;
    logic              frame_err_q;
    logic              overrun_q;
    logic              start_edge;
    logic              sample_now;
    logic              bit_s;
    logic              commit;
    logic [3:0]        cfg_nbits;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge UARTCLK) begin
                    if (PRESET) sync_q[gi] <= 1'b1;
                    else        sync_q[gi] <= UART_RXD;
                end
            end else begin : g_rest
                always_ff @(posedge UARTCLK) begin
                    if (PRESET) sync_q[gi] <= 1'b1;
                    else        sync_q[gi] <= sync_q[gi-1];
                end
            end
        end
    endgenerate

    assign rxd_s = sync_q[SYNC_STAGES-1];

`ifdef RX_MAJORITY_VOTE_EN
    // Two previous tick samples plus the current one form the vote at DEC_PHASE.
    logic [1:0] vote_q;
    always_ff @(posedge UARTCLK) begin
        if (PRESET)            vote_q <= 2'b11;
        else if (baud_tick_os) vote_q <= {vote_q[0], rxd_s};
    end
    assign bit_s = (vote_q[1] & vote_q[0]) | (vote_q[1] & rxd_s) | (vote_q[0] & rxd_s);
`else
    assign bit_s = rxd_s;
`endif

    // A falling edge is required, so a held-low line after a break never re-arms the detector.
    assign start_edge = (state_q == S_IDLE) && rxd_prev_q && !rxd_s;
    assign sample_now = baud_tick_os && (state_q != S_IDLE) && (tick_cnt_q == DEC_PHASE);
    assign cfg_nbits  = (number_data_receive < 4'd5) ? 4'd5 :
                        (number_data_receive > 4'd8) ? 4'd8 : number_data_receive;

    always_ff @(posedge UARTCLK) begin
        if (PRESET) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_edge) state_d = S_START;
            S_START:  if (sample_now) state_d = bit_s ? S_IDLE : S_DATA;
            S_DATA:   if (sample_now && ({1'b0, bit_cnt_q} == nbits_q - 4'd1))
                          state_d = par_en_q ? S_PARITY : S_STOP1;
            S_PARITY: if (sample_now) state_d = S_STOP1;
            S_STOP1:  if (sample_now) state_d = two_stop_q ? S_STOP2 : S_IDLE;
            S_STOP2:  if (sample_now) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rx_busy = (state_q != S_IDLE);
        commit  = sample_now &&
                  (((state_q == S_STOP1) && !two_stop_q) || (state_q == S_STOP2));
    end

    always_ff @(posedge UARTCLK) begin
        if (PRESET) begin
            rxd_prev_q <= 1'b1;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            nbits_q    <= 4'd0;
            par_en_q   <= 1'b0;
            par_even_q <= 1'b0;
            two_stop_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rxd_prev_q <= rxd_s;
            if (start_edge) begin
                tick_cnt_q <= '0;
                bit_cnt_q  <= '0;
                shreg_q    <= '0;
                perr_q     <= 1'b0;
                ferr_q     <= 1'b0;
                nbits_q    <= cfg_nbits;
                par_en_q   <= parity_en;
                par_even_q <= parity_bit_mode;
                two_stop_q <= stop_bit_twice;
            end else if (baud_tick_os && (state_q != S_IDLE)) begin
                tick_cnt_q <= tick_cnt_q + CW'(1);
            end
            if (sample_now) begin
                case (state_q)
                    S_DATA: begin
                        shreg_q[bit_cnt_q] <= bit_s;
                        bit_cnt_q          <= bit_cnt_q + 3'd1;
                    end
                    S_PARITY: perr_q <= ((^shreg_q) ^ bit_s) != !par_even_q;
                    S_STOP1, S_STOP2: if (!bit_s) ferr_q <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Held word is never overwritten unless it is popped in the same cycle.
    always_ff @(posedge UARTCLK) begin
        if (PRESET) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (commit) begin
                if (!rx_valid_q || rx_ready) begin
                    rx_data_q    <= shreg_q;
                    parity_err_q <= perr_q;
                    frame_err_q  <= ferr_q | !bit_s;
                    rx_valid_q   <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign parity_err  = parity_err_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: baud tick every 4 clocks, 64 clocks per serial bit.
module tb_uart_rx_deframer;

    localparam int BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       srst;
    logic       baud_tick;
    logic       rxd;
    logic [3:0] ndata;
    logic       par_en;
    logic       par_even;
    logic       two_stop;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun_err;
    logic       rx_busy;

    int checks   = 0;
    int failures = 0;
    int ovr_cnt  = 0;
    logic [1:0] tdiv = 2'd0;

    uart_rx_deframer dut (
        .UARTCLK             (clk),
        .PRESET              (srst),
        .baud_tick_os        (baud_tick),
        .UART_RXD            (rxd),
        .number_data_receive (ndata),
        .parity_en           (par_en),
        .parity_bit_mode     (par_even),
        .stop_bit_twice      (two_stop),
        .rx_data             (rx_data),
        .rx_valid            (rx_valid),
        .rx_ready            (rx_ready),
        .parity_err          (parity_err),
        .frame_err           (frame_err),
        .overrun_err         (overrun_err),
        .rx_busy             (rx_busy)
    );

    always #5 clk = ~clk;

    initial baud_tick = 1'b0;
    always @(posedge clk) begin
        tdiv      <= tdiv + 2'd1;
        baud_tick <= (tdiv == 2'd3);
    end

    always @(negedge clk) if (overrun_err === 1'b1) ovr_cnt++;

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic set_cfg(input logic [3:0] n, input logic pe, input logic ev, input logic ts);
        ndata = n; par_en = pe; par_even = ev; two_stop = ts;
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input logic has_par,
                              input logic par, input logic s1, input logic has_s2, input logic s2);
        drive_bit(1'b0);
        for (int i = 0; i < nb; i++) drive_bit(d[i]);
        if (has_par) drive_bit(par);
        drive_bit(s1);
        if (has_s2) drive_bit(s2);
        $display("frame data=%02h nb=%0d -> rx_valid=%0b rx_data=%02h perr=%0b ferr=%0b",
                 d, nb, rx_valid, rx_data, parity_err, frame_err);
    endtask

    task automatic pop_word();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        srst = 1'b1; rxd = 1'b1; rx_ready = 1'b0;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        srst = 1'b0;
        @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b exp 0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %02h exp 00", rx_data); end
        checks++; if ({parity_err, frame_err, overrun_err} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %03b exp 000", {parity_err, frame_err, overrun_err}); end
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b exp 0", rx_busy); end
        repeat (BIT_CLKS) @(negedge clk);
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy: got %0b exp 0", rx_busy); end
    endtask

    task automatic test_parity();
        set_cfg(4'd8, 1'b1, 1'b1, 1'b1);
        send_frame(8'h6D, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL e82_valid: got %0b exp 1", rx_valid); end
        checks++; if (rx_data !== 8'h6D) begin failures++; $display("FAIL e82_data: got %02h exp 6d", rx_data); end
        checks++; if ({parity_err, frame_err} !== 2'b00) begin failures++; $display("FAIL e82_flags: got %02b exp 00", {parity_err, frame_err}); end
        pop_word();
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL e82_pop: got %0b exp 0", rx_valid); end
        send_frame(8'h6D, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        checks++; if (rx_data !== 8'h6D) begin failures++; $display("FAIL e82bad_data: got %02h exp 6d", rx_data); end
        checks++; if (parity_err !== 1'b1) begin failures++; $display("FAIL e82bad_perr: got %0b exp 1", parity_err); end
        pop_word();
        // number_data_receive=3 clamps to 5 data bits
        set_cfg(4'd3, 1'b1, 1'b0, 1'b0);
        send_frame(8'h15, 5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if (rx_data !== 8'h15) begin failures++; $display("FAIL o51_data: got %02h exp 15", rx_data); end
        checks++; if ({rx_valid, parity_err, frame_err} !== 3'b100) begin failures++; $display("FAIL o51_flags: got %03b exp 100", {rx_valid, parity_err, frame_err}); end
        pop_word();
    endtask

    task automatic test_frame_err();
        // number_data_receive=12 clamps to 8 data bits
        set_cfg(4'd12, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL ferr_data: got %02h exp a5", rx_data); end
        checks++; if ({rx_valid, frame_err} !== 2'b11) begin failures++; $display("FAIL ferr_flag: got %02b exp 11", {rx_valid, frame_err}); end
        drive_bit(1'b1);
        pop_word();
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if (rx_data !== 8'h3C) begin failures++; $display("FAIL ferr_next_data: got %02h exp 3c", rx_data); end
        checks++; if ({rx_valid, parity_err, frame_err} !== 3'b100) begin failures++; $display("FAIL ferr_next_flags: got %03b exp 100", {rx_valid, parity_err, frame_err}); end
        pop_word();
    endtask

    task automatic test_break();
        send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if ({rx_valid, rx_data, frame_err} !== {1'b1, 8'h00, 1'b1}) begin failures++; $display("FAIL break_word: got v=%0b d=%02h f=%0b exp v=1 d=00 f=1", rx_valid, rx_data, frame_err); end
        pop_word();
        repeat (2 * BIT_CLKS) @(negedge clk);
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL break_rearm: got busy=%0b exp 0", rx_busy); end
        drive_bit(1'b1);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if ({rx_valid, rx_data, frame_err} !== {1'b1, 8'h3C, 1'b0}) begin failures++; $display("FAIL break_next: got v=%0b d=%02h f=%0b exp v=1 d=3c f=0", rx_valid, rx_data, frame_err); end
        pop_word();
    endtask

    task automatic test_false_start();
        rxd = 1'b0;
        repeat (16) @(negedge clk);
        checks++; if (rx_busy !== 1'b1) begin failures++; $display("FAIL fstart_busy: got %0b exp 1", rx_busy); end
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL fstart_idle: got %0b exp 0", rx_busy); end
        repeat (2 * BIT_CLKS) @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL fstart_valid: got %0b exp 0", rx_valid); end
        $display("false start done busy=%0b valid=%0b", rx_busy, rx_valid);
    endtask

    task automatic test_back_to_back_overrun();
        int ovr0;
        ovr0 = ovr_cnt;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if (ovr_cnt - ovr0 !== 1) begin failures++; $display("FAIL ovr_pulse: got %0d cycles exp 1", ovr_cnt - ovr0); end
        checks++; if ({rx_valid, rx_data} !== {1'b1, 8'h11}) begin failures++; $display("FAIL ovr_keep: got v=%0b d=%02h exp v=1 d=11", rx_valid, rx_data); end
        pop_word();
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL ovr_pop: got %0b exp 0", rx_valid); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        d = 8'h6D;
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d[i]);
        rxd = d[3];
        repeat (32) @(negedge clk);
        checks++; if ({rx_busy, rx_valid} !== 2'b11) begin failures++; $display("FAIL midrst_pre: got busy/valid=%02b exp 11", {rx_busy, rx_valid}); end
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0; rxd = 1'b1;
        checks++; if ({rx_busy, rx_valid, rx_data, parity_err, frame_err, overrun_err} !== 13'd0) begin failures++; $display("FAIL midrst_clear: got busy=%0b v=%0b d=%02h flags=%03b exp all 0", rx_busy, rx_valid, rx_data, {parity_err, frame_err, overrun_err}); end
        repeat (BIT_CLKS) @(negedge clk);
        send_frame(8'h6D, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if ({rx_valid, rx_data, parity_err, frame_err} !== {1'b1, 8'h6D, 2'b00}) begin failures++; $display("FAIL midrst_next: got v=%0b d=%02h pf=%02b exp v=1 d=6d pf=00", rx_valid, rx_data, {parity_err, frame_err}); end
        pop_word();
    endtask

`ifdef RX_MAJORITY_VOTE_EN
    task automatic test_glitch();
        logic [7:0] d;
        d = 8'h6D;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                rxd = 1'b1; repeat (28) @(negedge clk);
                rxd = 1'b0; repeat (4) @(negedge clk);
                rxd = 1'b1; repeat (32) @(negedge clk);
            end else begin
                drive_bit(d[i]);
            end
        end
        drive_bit(1'b1);
        $display("glitch frame -> rx_valid=%0b rx_data=%02h", rx_valid, rx_data);
        checks++; if ({rx_valid, rx_data, frame_err} !== {1'b1, 8'h6D, 1'b0}) begin failures++; $display("FAIL glitch_vote: got v=%0b d=%02h f=%0b exp v=1 d=6d f=0", rx_valid, rx_data, frame_err); end
        pop_word();
    endtask
`endif

    initial begin
        test_reset();
        test_parity();
        test_frame_err();
        test_break();
        test_false_start();
        test_back_to_back_overrun();
        test_reset_mid_frame();
`ifdef RX_MAJORITY_VOTE_EN
        test_glitch();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
